// File: rtl/usb_30_rx_symbol_aligner_pkg.sv
// ============================================================================
//  Module      : usb_30_pkg
//  Description : Shared symbol constants and aligner state type for the
//                USB 3.0 RX symbol aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_30_pkg;

    localparam int SYM_W = 10;

    // K28.5 in both running disparities, bit 9 first on the wire
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic is_comma(input logic [SYM_W-1:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_30_sync_fifo.sv
// ============================================================================
//  Module      : usb_30_sync_fifo
//  Description : Single-clock FIFO; head is presented from storage so data
//                is visible the cycle after the push.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_30_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_30_rx_symbol_aligner.sv
// ============================================================================
//  Module      : usb_30_rx_symbol_aligner
//  Description : Finds K28.5 commas in the raw PHY word stream, locks to a
//                bit offset and emits aligned symbols through a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_30_rx_symbol_aligner
    import usb_30_pkg::*;
#(
    parameter int LOCK_COUNT    = 3,
    parameter int ERR_LIMIT     = 4,
    parameter int COMMA_TIMEOUT = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk_phy,
    input  logic             rst_phy,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_valid,
    output logic [SYM_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_comma,
    output logic             locked,
    output logic [3:0]       align_offset,
    output logic             overflow
);

    localparam int c_CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int c_MIS_W = $clog2(ERR_LIMIT + 1);
    localparam int c_TO_W  = $clog2(COMMA_TIMEOUT + 1);

    logic [SYM_W-1:0]   r_prev_word;
    logic               r_prev_vld;
    align_state_e       r_state;
    align_state_e       w_state_nxt;
    logic [3:0]         r_offset;
    logic [3:0]         w_offset_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_MIS_W-1:0] r_mis;
    logic [c_MIS_W-1:0] w_mis_nxt;
    logic [c_TO_W-1:0]  r_to;
    logic [c_TO_W-1:0]  w_to_nxt;
    logic               r_overflow;

    logic [2*SYM_W-1:0] w_window;
    logic [SYM_W-1:0]   w_cand [SYM_W];
    logic [SYM_W-1:0]   w_cand_hit;
    logic               w_acc;
    logic               w_hit;
    logic [3:0]         w_hit_k;
    logic               w_cnt_done;
    logic               w_mis_done;
    logic               w_to_done;
    logic               w_lose;
    logic               w_push;
    logic [SYM_W-1:0]   w_push_sym;
    logic               w_push_comma;
    logic [SYM_W:0]     w_fifo_q;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    assign w_window = {r_prev_word, in_data};
    assign w_acc    = in_valid && r_prev_vld;

    generate
        for (genvar k = 0; k < SYM_W; k++) begin : g_cand
            assign w_cand[k]     = w_window[2*SYM_W-1-k -: SYM_W];
            assign w_cand_hit[k] = is_comma(w_cand[k]);
        end
    endgenerate

    // scanning downward leaves the lowest matching offset as the winner
    always_comb begin : p_hit
        w_hit   = 1'b0;
        w_hit_k = '0;
        for (int k = SYM_W - 1; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                w_hit   = 1'b1;
                w_hit_k = 4'(k);
            end
        end
    end

    // limits are checked before incrementing, so counters never pass them
    assign w_cnt_done = (int'(r_cnt) + 1) >= LOCK_COUNT;
    assign w_mis_done = (int'(r_mis) + 1) >= ERR_LIMIT;
    assign w_to_done  = (int'(r_to) + 1) >= COMMA_TIMEOUT;

    always_comb begin : p_fsm
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_cnt_nxt    = r_cnt;
        w_mis_nxt    = r_mis;
        w_to_nxt     = r_to;
        w_push       = 1'b0;
        w_lose       = 1'b0;
        if (w_acc) begin
            unique case (r_state)
                HUNT: begin
                    if (w_hit) begin
                        w_offset_nxt = w_hit_k;
                        w_cnt_nxt    = c_CNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            w_state_nxt = LOCKED;
                            w_push      = 1'b1;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (w_hit) begin
                        w_to_nxt = '0;
                        if (w_hit_k == r_offset) begin
                            if (w_cnt_done) begin
                                w_state_nxt = LOCKED;
                                w_mis_nxt   = '0;
                                w_push      = 1'b1;
                            end
                            w_cnt_nxt = w_cnt_done ? r_cnt : r_cnt + 1'b1;
                        end else begin
                            w_offset_nxt = w_hit_k;
                            w_cnt_nxt    = c_CNT_W'(1);
                        end
                    end else if (w_to_done) begin
                        w_lose = 1'b1;
                    end else begin
                        w_to_nxt = r_to + 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_to_nxt = '0;
                        if (w_hit_k == r_offset) begin
                            w_mis_nxt = '0;
                            w_push    = 1'b1;
                        end else if (w_mis_done) begin
                            w_lose = 1'b1;
                        end else begin
                            w_mis_nxt = r_mis + 1'b1;
                            w_push    = 1'b1;
                        end
                    end else if (w_to_done) begin
                        w_lose = 1'b1;
                    end else begin
                        w_to_nxt = r_to + 1'b1;
                        w_push   = 1'b1;
                    end
                end
                default: w_lose = 1'b1;
            endcase
            if (w_lose) begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
                w_mis_nxt   = '0;
                w_to_nxt    = '0;
                w_push      = 1'b0;
            end
        end
    end

    // the pushed symbol is taken at the offset in force after this word
    always_comb begin : p_sym
        w_push_sym   = '0;
        w_push_comma = 1'b0;
        for (int k = 0; k < SYM_W; k++) begin
            if (w_offset_nxt == 4'(k)) begin
                w_push_sym   = w_cand[k];
                w_push_comma = w_cand_hit[k];
            end
        end
    end

    assign w_pop = out_ready && !w_empty;

    always_ff @(posedge clk_phy) begin
        if (rst_phy) begin
            r_prev_word <= '0;
            r_prev_vld  <= 1'b0;
            r_state     <= HUNT;
            r_offset    <= '0;
            r_cnt       <= '0;
            r_mis       <= '0;
            r_to        <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (in_valid) begin
                r_prev_word <= in_data;
                r_prev_vld  <= 1'b1;
            end
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mis    <= w_mis_nxt;
            r_to     <= w_to_nxt;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    usb_30_sync_fifo #(
        .WIDTH (SYM_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_phy),
        .rst     (rst_phy),
        .i_push  (w_push),
        .i_data  ({w_push_comma, w_push_sym}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid    = !w_empty;
    assign out_data     = w_fifo_q[SYM_W-1:0];
    assign out_comma    = w_fifo_q[SYM_W];
    assign locked       = (r_state == LOCKED);
    assign align_offset = r_offset;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_usb_30_rx_symbol_aligner.sv
// ============================================================================
//  Module      : tb_usb_30_rx_symbol_aligner
//  Description : Randomised and directed bench with a bit-stream generator,
//                a behavioural aligner model and a scoreboard monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_30_rx_symbol_aligner;

    localparam int LOCK_COUNT    = 3;
    localparam int ERR_LIMIT     = 4;
    localparam int COMMA_TIMEOUT = 1024;
    localparam int FIFO_DEPTH    = 4;

    localparam logic [9:0] K_RDN = 10'b0011111010;
    localparam logic [9:0] K_RDP = 10'b1100000101;
    localparam logic [9:0] D215  = 10'b1010101010;

    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic       clk_phy = 1'b0;
    logic       rst_phy = 1'b1;
    logic [9:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_comma;
    logic       locked;
    logic [3:0] align_offset;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    bit          bitq[$];
    logic [10:0] sbq[$];

    // behavioural model of the aligner and FIFO occupancy
    int         m_state, m_off, m_cnt, m_mis, m_to, m_count;
    logic [9:0] m_prev;
    bit         m_prev_vld, m_ovf;

    usb_30_rx_symbol_aligner #(
        .LOCK_COUNT    (LOCK_COUNT),
        .ERR_LIMIT     (ERR_LIMIT),
        .COMMA_TIMEOUT (COMMA_TIMEOUT),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk_phy      (clk_phy),
        .rst_phy      (rst_phy),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_comma    (out_comma),
        .locked       (locked),
        .align_offset (align_offset),
        .overflow     (overflow)
    );

    always #5 clk_phy = ~clk_phy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_k(input logic [9:0] s);
        return (s == K_RDN) || (s == K_RDP);
    endfunction

    task automatic add_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bitq.push_back(s[i]);
    endtask

    task automatic add_bits(input int n, input bit rnd);
        for (int i = 0; i < n; i++) bitq.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic take_word(output logic [9:0] w);
        while (bitq.size() < 10) add_sym(D215);
        for (int i = 9; i >= 0; i--) w[i] = bitq.pop_front();
    endtask

    task automatic model_reset();
        m_state = M_HUNT; m_off = 0; m_cnt = 0; m_mis = 0; m_to = 0;
        m_count = 0; m_prev = '0; m_prev_vld = 0; m_ovf = 0;
        sbq.delete();
    endtask

    task automatic go_hunt();
        m_state = M_HUNT; m_cnt = 0; m_mis = 0; m_to = 0;
    endtask

    // predicts the state after the coming clock edge and queues emissions
    task automatic model_step(input bit v, input logic [9:0] d, input bit rdy);
        logic [19:0] w;
        logic [9:0]  c;
        bit          push, hit, pop;
        int          hk;
        push = 0; hit = 0; hk = 0;
        pop  = (m_count > 0) && rdy;
        w    = {m_prev, d};
        if (v && m_prev_vld) begin
            for (int k = 9; k >= 0; k--) begin
                c = w[19-k -: 10];
                if (is_k(c)) begin hit = 1; hk = k; end
            end
            if (m_state == M_HUNT) begin
                if (hit) begin
                    m_off = hk; m_cnt = 1;
                    m_state = (LOCK_COUNT == 1) ? M_LOCKED : M_VERIFY;
                    push = (LOCK_COUNT == 1);
                end
            end else begin
                m_to = hit ? 0 : m_to + 1;
                if (m_to >= COMMA_TIMEOUT) go_hunt();
                else if (m_state == M_VERIFY) begin
                    if (hit && hk == m_off) begin
                        m_cnt++;
                        if (m_cnt >= LOCK_COUNT) begin m_state = M_LOCKED; m_mis = 0; push = 1; end
                    end else if (hit) begin
                        m_off = hk; m_cnt = 1;
                    end
                end else begin
                    if (hit) m_mis = (hk == m_off) ? 0 : m_mis + 1;
                    if (m_mis >= ERR_LIMIT) go_hunt();
                    else push = 1;
                end
            end
        end
        if (v) begin m_prev = d; m_prev_vld = 1; end
        if (push) begin
            c = w[19-m_off -: 10];
            if (m_count < FIFO_DEPTH || pop) begin
                sbq.push_back({is_k(c), c});
                m_count++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_count--;
    endtask

    // one clock: drive, predict, then compare the registered status
    task automatic step(input bit v, input bit rdy);
        logic [9:0] w;
        if (v) take_word(w);
        else   w = 10'($urandom);
        in_valid  = v;
        in_data   = w;
        out_ready = rdy;
        model_step(v, w, rdy);
        @(posedge clk_phy);
        #1;
        chk("locked", int'(locked), int'(m_state == M_LOCKED));
        chk("align_offset", int'(align_offset), m_off);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("out_valid", int'(out_valid), int'(m_count > 0));
    endtask

    task automatic do_reset();
        rst_phy   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 10'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk_phy);
        #1;
        rst_phy = 1'b0;
        model_reset();
        bitq.delete();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_offset", int'(align_offset), 0);
        chk("rst_out_comma", int'(out_comma), 0);
        chk("rst_out_data", int'(out_data), 0);
    endtask

    task automatic lock_at3();
        add_bits(3, 0);
        for (int i = 0; i < 3; i++) begin
            add_sym(i[0] ? K_RDP : K_RDN);
            add_sym(D215);
        end
        for (int i = 0; i < 6; i++) step(1, 1);
    endtask

    always @(negedge clk_phy) begin
        if (!rst_phy && out_valid && out_ready) begin
            logic [10:0] e;
            if (sbq.size() == 0) begin
                chk("unexpected_output", int'({out_comma, out_data}), -1);
            end else begin
                e = sbq.pop_front();
                chk("out_data", int'(out_data), int'(e[9:0]));
                chk("out_comma", int'(out_comma), int'(e[10]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // lock at offset 3 with commas interleaved with D21.5
        add_bits(3, 0);
        for (int i = 0; i < 3; i++) begin
            add_sym(i[0] ? K_RDP : K_RDN);
            add_sym(D215);
        end
        for (int i = 0; i < 5; i++) step(1, 1);
        chk("lock_before_3rd", int'(locked), 0);
        step(1, 1);
        chk("lock_on_3rd", int'(locked), 1);
        chk("lock_offset", int'(align_offset), 3);

        // foreign commas at offset 7: three tolerated, fourth drops lock
        add_bits(4, 0);
        for (int i = 0; i < 3; i++) begin add_sym(K_RDN); add_sym(D215); end
        add_bits(6, 0);
        add_sym(K_RDP); add_sym(D215);
        while (bitq.size() >= 10) step(1, 1);
        chk("lock_held_burst", int'(locked), 1);
        add_bits(4, 0);
        for (int i = 0; i < 4; i++) begin add_sym(K_RDN); add_sym(D215); end
        while (bitq.size() >= 10) step(1, 1);
        chk("lock_lost_burst", int'(locked), 0);

        // comma starvation
        do_reset();
        lock_at3();
        for (int i = 0; i < COMMA_TIMEOUT; i++) add_sym(D215);
        for (int i = 0; i < COMMA_TIMEOUT - 1; i++) step(1, 1);
        chk("lock_before_timeout", int'(locked), 1);
        step(1, 1);
        chk("lock_timeout", int'(locked), 0);

        do_reset();
        lock_at3();
        for (int i = 0; i < COMMA_TIMEOUT - 3; i++) add_sym(D215);
        add_sym(K_RDN);
        for (int i = 0; i < 20; i++) add_sym(D215);
        for (int i = 0; i < COMMA_TIMEOUT + 6; i++) step(1, 1);
        chk("lock_refreshed", int'(locked), 1);

        // backpressure, overflow and drain
        do_reset();
        lock_at3();
        for (int i = 0; i < 3; i++) step(1, 1);
        for (int i = 0; i < 3; i++) step(0, 1);
        for (int i = 0; i < 6; i++) step(1, 0);
        chk("ovf_set", int'(overflow), 1);
        for (int i = 0; i < 5; i++) step(0, 1);
        chk("ovf_sticky", int'(overflow), 1);

        // reset with a full FIFO while locked
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("full_before_rst", int'(out_valid), 1);
        do_reset();
        step(1, 1);
        step(1, 1);
        chk("post_rst_quiet", int'(out_valid), 0);

        // randomised traffic with alignment slips and random data
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if (bitq.size() < 20) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 25)      add_sym($urandom_range(0, 1) ? K_RDN : K_RDP);
                else if (r < 33) add_bits($urandom_range(1, 9), 1);
                else if (r < 70) add_sym(D215);
                else             add_sym(10'($urandom));
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++) step(0, 1);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
